// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like N-to-1 arbiter: size codes, channel-ID
// width helper and the round-robin successor function.
package sram_like_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MAX_NCH = 8;

  // Channel-ID width; a single channel still needs one bit to index.
  function automatic int id_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam int CH_ID_W_MAX = id_width(MAX_NCH);

  function automatic int rr_next(input int idx, input int nch);
    return (idx + 1 >= nch) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// In-order FIFO of channel IDs for accepted-but-unanswered transactions.
module sram_like_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [W-1:0]                 push_id,
  input  logic                         pop,
  output logic [W-1:0]                 head_id,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  // NOTE: storage needs no reset; count/empty guarantee a stale entry is never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges NCH sram-like request ports onto one downstream port with in-order
// response routing, grant lock under back-pressure and RR / fixed priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OUTST = 4,
  parameter int RR    = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NCH-1:0]               s_req,
  input  logic [NCH-1:0]               s_wr,
  input  logic [2*NCH-1:0]             s_size,
  input  logic [AW*NCH-1:0]            s_addr,
  input  logic [(DW/8)*NCH-1:0]        s_wstrb,
  input  logic [DW*NCH-1:0]            s_wdata,
  output logic [NCH-1:0]               s_addr_ok,
  output logic [NCH-1:0]               s_data_ok,
  output logic [DW-1:0]                s_rdata,
  output logic                         m_req,
  output logic                         m_wr,
  output logic [1:0]                   m_size,
  output logic [AW-1:0]                m_addr,
  output logic [DW/8-1:0]              m_wstrb,
  output logic [DW-1:0]                m_wdata,
  input  logic                         m_addr_ok,
  input  logic                         m_data_ok,
  input  logic [DW-1:0]                m_rdata,
  output logic [$clog2(OUTST+1)-1:0]   outstanding,
  output logic                         proto_err
);

  localparam int IDW = id_width(NCH);
  localparam int SW  = DW / 8;

  logic [IDW-1:0] rr_ptr;
  logic           lock_v;
  logic [IDW-1:0] lock_idx;
  logic [IDW-1:0] scan_grant;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] head_id;
  logic           full;
  logic           empty;
  logic           hs;
  logic           pop;

  // Priority distance: offset from rr_ptr in RR mode, plain index otherwise.
  always_comb begin
    int d;
    int best_d;
    scan_grant = '0;
    best_d     = NCH;
    d          = 0;
    for (int i = 0; i < NCH; i++) begin
      if (RR != 0) begin
        d = i - int'(rr_ptr);
        if (d < 0) d = d + NCH;
      end else begin
        d = i;
      end
      if (s_req[i] && d < best_d) begin
        best_d     = d;
        scan_grant = IDW'(i);
      end
    end
  end

  assign grant = lock_v ? lock_idx : scan_grant;
  // Reset gates m_req directly so nothing is offered while resetn is low.
  assign m_req = resetn & ((|s_req) | lock_v) & ~full;
  assign hs    = m_req & m_addr_ok;
  assign sel   = m_req ? grant : '0;
  assign pop   = m_data_ok & ~empty;

  // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    m_wr    = s_wr[0];
    m_size  = s_size[1:0];
    m_addr  = s_addr[AW-1:0];
    m_wstrb = s_wstrb[SW-1:0];
    m_wdata = s_wdata[DW-1:0];
    for (int i = 1; i < NCH; i++) begin
      if (sel == IDW'(i)) begin
        m_wr    = s_wr[i];
        m_size  = s_size[2*i +: 2];
        m_addr  = s_addr[AW*i +: AW];
        m_wstrb = s_wstrb[SW*i +: SW];
        m_wdata = s_wdata[DW*i +: DW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      s_addr_ok[i] = hs & (grant == IDW'(i));
      s_data_ok[i] = pop & (head_id == IDW'(i));
    end
  end

  assign s_rdata = m_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      lock_v    <= 1'b0;
      lock_idx  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (hs) begin
        lock_v <= 1'b0;
        if (RR != 0) rr_ptr <= IDW'(rr_next(int'(grant), NCH));
      end else if (m_req) begin
        lock_v   <= 1'b1;
        lock_idx <= grant;
      end
      if (m_data_ok && empty) proto_err <= 1'b1;
    end
  end

  sram_like_id_fifo #(
    .DEPTH (OUTST),
    .W     (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (hs),
    .push_id (grant),
    .pop     (m_data_ok),
    .head_id (head_id),
    .full    (full),
    .empty   (empty),
    .count   (outstanding)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed + random bench: a round-robin and a fixed-priority instance share
// stimulus; each is checked every cycle against a queue-based reference model.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int NCH   = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int OUTST = 4;
  localparam int CW    = $clog2(OUTST + 1);
  localparam int SW    = DW / 8;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NCH-1:0]       s_req, s_wr;
  logic [2*NCH-1:0]     s_size;
  logic [AW*NCH-1:0]    s_addr;
  logic [SW*NCH-1:0]    s_wstrb;
  logic [DW*NCH-1:0]    s_wdata;
  logic                 m_addr_ok, m_data_ok;
  logic [DW-1:0]        m_rdata;

  logic [NCH-1:0]       s_addr_ok [2];
  logic [NCH-1:0]       s_data_ok [2];
  logic [DW-1:0]        s_rdata   [2];
  logic                 m_req     [2];
  logic                 m_wr      [2];
  logic [1:0]           m_size    [2];
  logic [AW-1:0]        m_addr    [2];
  logic [SW-1:0]        m_wstrb   [2];
  logic [DW-1:0]        m_wdata   [2];
  logic [CW-1:0]        outstanding [2];
  logic                 proto_err [2];

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    sram_like_arbiter #(
      .NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST), .RR((k == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
      .s_wstrb(s_wstrb), .s_wdata(s_wdata),
      .s_addr_ok(s_addr_ok[k]), .s_data_ok(s_data_ok[k]), .s_rdata(s_rdata[k]),
      .m_req(m_req[k]), .m_wr(m_wr[k]), .m_size(m_size[k]), .m_addr(m_addr[k]),
      .m_wstrb(m_wstrb[k]), .m_wdata(m_wdata[k]),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .outstanding(outstanding[k]), .proto_err(proto_err[k])
    );
  end

  // Reference model state per instance.
  int  rr_m   [2];
  bit  lock_m [2];
  int  lidx_m [2];
  int  ids_m  [2][OUTST+1];
  int  n_m    [2];
  bit  perr_m [2];
  int  g_s    [2];
  bit  mreq_s [2];
  bit  hs_s   [2];
  bit  pop_s  [2];

  int errors = 0;
  int checks = 0;
  int accepts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rr_m[k] = 0; lock_m[k] = 0; lidx_m[k] = 0; n_m[k] = 0; perr_m[k] = 0;
    end
  endtask

  function automatic int model_grant(input int k);
    if (lock_m[k]) return lidx_m[k];
    for (int d = 0; d < NCH; d++) begin
      int c;
      c = (k == 0) ? (rr_m[k] + d) % NCH : d;
      if (s_req[c]) return c;
    end
    return 0;
  endfunction

  task automatic set_ch(input int ch, input logic [AW-1:0] addr, input logic wr,
                        input logic [1:0] size, input logic [SW-1:0] strb,
                        input logic [DW-1:0] wdata);
    s_addr[ch*AW +: AW]  = addr;
    s_wr[ch]             = wr;
    s_size[ch*2 +: 2]    = size;
    s_wstrb[ch*SW +: SW] = strb;
    s_wdata[ch*DW +: DW] = wdata;
  endtask

  // Compare every output of both instances against the model, mid-cycle.
  task automatic settle();
    #1;
    for (int k = 0; k < 2; k++) begin
      int    sel;
      string nm;
      nm        = (k == 0) ? "rr" : "fp";
      g_s[k]    = model_grant(k);
      mreq_s[k] = resetn && (s_req != '0 || lock_m[k]) && n_m[k] < OUTST;
      hs_s[k]   = mreq_s[k] && m_addr_ok;
      pop_s[k]  = m_data_ok && n_m[k] > 0;
      sel       = mreq_s[k] ? g_s[k] : 0;
      check({nm, " m_req"}, 64'(m_req[k]), 64'(mreq_s[k]));
      check({nm, " m_addr"}, 64'(m_addr[k]), 64'(s_addr[sel*AW +: AW]));
      check({nm, " m_wr"}, 64'(m_wr[k]), 64'(s_wr[sel]));
      check({nm, " m_size"}, 64'(m_size[k]), 64'(s_size[sel*2 +: 2]));
      check({nm, " m_wstrb"}, 64'(m_wstrb[k]), 64'(s_wstrb[sel*SW +: SW]));
      check({nm, " m_wdata"}, 64'(m_wdata[k]), 64'(s_wdata[sel*DW +: DW]));
      check({nm, " s_addr_ok"}, 64'(s_addr_ok[k]), hs_s[k] ? (64'd1 << g_s[k]) : 64'd0);
      check({nm, " s_data_ok"}, 64'(s_data_ok[k]), pop_s[k] ? (64'd1 << ids_m[k][0]) : 64'd0);
      check({nm, " s_rdata"}, 64'(s_rdata[k]), 64'(m_rdata));
      check({nm, " outstanding"}, 64'(outstanding[k]), 64'(n_m[k]));
      check({nm, " proto_err"}, 64'(proto_err[k]), 64'(perr_m[k]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        rr_m[k] = 0; lock_m[k] = 0; n_m[k] = 0; perr_m[k] = 0;
      end else begin
        if (pop_s[k]) begin
          for (int j = 0; j < OUTST; j++) ids_m[k][j] = ids_m[k][j+1];
          n_m[k]--;
        end else if (m_data_ok) begin
          perr_m[k] = 1;
        end
        if (hs_s[k]) begin
          ids_m[k][n_m[k]] = g_s[k];
          n_m[k]++;
          if (k == 0) rr_m[k] = (g_s[k] + 1) % NCH;
          lock_m[k] = 0;
        end else if (mreq_s[k]) begin
          lock_m[k] = 1;
          lidx_m[k] = g_s[k];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    resetn = 1'b0; s_req = '1; s_wr = '0; s_size = '0; s_addr = '0;
    s_wstrb = '0; s_wdata = '0; m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = '0;
    model_reset();
    set_ch(0, 32'h0000_1000, 1'b0, SZ_WORD, 4'hF, 32'h1111_0000);
    set_ch(1, 32'h1FC0_0004, 1'b0, SZ_WORD, 4'hF, 32'h2222_0000);
    @(negedge clk);
    settle();
    check("reset m_req", 64'(m_req[0]), 64'd0);
    check("reset saok", 64'(s_addr_ok[1]), 64'd0);
    advance();
    resetn = 1'b1; s_req = '0;
    step();

    // Single ch1 read answered two cycles after acceptance.
    s_req = 2'b10;
    settle();
    check("A saok", 64'(s_addr_ok[0]), 64'b10);
    check("A out0", 64'(outstanding[0]), 64'd0);
    advance();
    s_req = 2'b00;
    settle();
    check("A out1", 64'(outstanding[0]), 64'd1);
    advance();
    m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
    settle();
    check("A sdok", 64'(s_data_ok[0]), 64'b10);
    check("A rdata", 64'(s_rdata[0]), 64'hDEAD_BEEF);
    advance();
    m_data_ok = 1'b0;
    settle();
    check("A out2", 64'(outstanding[0]), 64'd0);
    advance();

    // Both channels request continuously with an always-ready slave.
    s_req = 2'b11; m_addr_ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m_data_ok = (c > 0); m_rdata = 32'hA000_0000 + 32'(c);
      settle();
      check("B rr grant", 64'(s_addr_ok[0]), (c % 2 == 0) ? 64'b01 : 64'b10);
      check("B fp grant", 64'(s_addr_ok[1]), 64'b01);
      if (c > 0) check("B rr resp", 64'(s_data_ok[0]), (c % 2 == 1) ? 64'b01 : 64'b10);
      advance();
    end
    s_req = 2'b00; m_data_ok = 1'b1;
    step();
    m_data_ok = 1'b0;

    // Back-pressure locks the grant while ch0 drops and ch1 raises.
    s_req = 2'b11; m_addr_ok = 1'b0;
    step();
    s_req = 2'b10;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("C lock req", 64'(m_req[1]), 64'd1);
      check("C lock addr", 64'(m_addr[1]), 64'h0000_1000);
      advance();
    end
    m_addr_ok = 1'b1;
    settle();
    check("C fp accept", 64'(s_addr_ok[1]), 64'b01);
    check("C rr accept", 64'(s_addr_ok[0]), 64'b01);
    advance();
    s_req = 2'b00; m_data_ok = 1'b1;
    step();
    m_data_ok = 1'b0;

    // Fill to OUTST with no responses, then a response alongside a pending request.
    s_req = 2'b01; accepts = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      accepts += int'(s_addr_ok[0][0]);
      advance();
    end
    check("D accepts", 64'(accepts), 64'd4);
    m_data_ok = 1'b1;
    settle();
    check("D full m_req", 64'(m_req[0]), 64'd0);
    check("D full out", 64'(outstanding[0]), 64'd4);
    check("D pop sdok", 64'(s_data_ok[0]), 64'b01);
    check("D no accept", 64'(s_addr_ok[0]), 64'd0);
    advance();
    m_data_ok = 1'b0;
    settle();
    check("D out after pop", 64'(outstanding[0]), 64'd3);
    check("D late accept", 64'(s_addr_ok[0]), 64'b01);
    advance();
    settle();
    check("D refill", 64'(outstanding[0]), 64'd4);
    advance();
    s_req = 2'b00; m_data_ok = 1'b1;
    repeat (4) step();
    m_data_ok = 1'b0;

    // Response with nothing in flight.
    m_data_ok = 1'b1;
    settle();
    check("E no sdok", 64'(s_data_ok[0]), 64'd0);
    advance();
    m_data_ok = 1'b0;
    settle();
    check("E perr set", 64'(proto_err[0]), 64'd1);
    advance();
    repeat (3) step();

    // Reset with three transactions in flight.
    s_req = 2'b01;
    repeat (3) step();
    s_req = 2'b00;
    settle();
    check("F out3", 64'(outstanding[0]), 64'd3);
    check("F perr sticky", 64'(proto_err[1]), 64'd1);
    advance();
    resetn = 1'b0; s_req = 2'b11; m_data_ok = 1'b1;
    model_reset();
    settle();
    check("F rst out", 64'(outstanding[0]), 64'd0);
    check("F rst saok", 64'(s_addr_ok[0]), 64'd0);
    check("F rst sdok", 64'(s_data_ok[0]), 64'd0);
    check("F rst perr", 64'(proto_err[0]), 64'd0);
    advance();
    resetn = 1'b1; s_req = 2'b00; m_data_ok = 1'b0;
    step();
    s_req = 2'b10;
    settle();
    check("F resume saok", 64'(s_addr_ok[0]), 64'b10);
    advance();
    s_req = 2'b00; m_data_ok = 1'b1; m_rdata = 32'h0BAD_F00D;
    settle();
    check("F resume sdok", 64'(s_data_ok[0]), 64'b10);
    advance();
    m_data_ok = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      s_req     = NCH'($urandom_range(0, 3));
      for (int ch = 0; ch < NCH; ch++)
        set_ch(ch, $urandom, 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom), $urandom);
      m_addr_ok = ($urandom_range(0, 3) != 0);
      m_data_ok = ($urandom_range(0, 2) != 0) && (n_m[0] > 0);
      m_rdata   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
